sha256_block_ctrl: RTL and testbench

//  Sequencer for the SHA-256 message schedule datapath and the hash core.

---
 rtl/sha256_block_ctrl.sv | 127 ++++++++++++
 tb/tb_sha256_block_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// Buffers one 16-word SHA-256 block and replays it as 16 load + 48 expand cycles feeding 64 core rounds.
// Buffer full to core_update is 66 cycles; in_ready drops while the buffer is full or being replayed.
module sha256_block_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        abort,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_first,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] ms_data,
   output logic        ms_write_enable,
   output logic        ms_inner_busy,
   output logic        core_init,
   output logic        core_round_en,
   output logic [5:0]  core_round_idx,
   output logic        core_update,
   output logic        digest_valid,
   input  logic        digest_ready,
   output logic        busy
);

   localparam int BLOCK_WORDS = 16;
   localparam int ROUNDS      = 64;

   typedef enum logic [1:0] {IDLE, RUN, UPDATE, DONE} state_t;

   state_t      state, state_nxt, resume_state;
   logic [6:0]  c, c_nxt;
   logic [4:0]  fill_cnt;
   logic [31:0] blk_buf [BLOCK_WORDS];
   logic        buf_first, buf_last, run_last;
   logic        buf_full, load_phase, load_end, xfer;

   assign buf_full   = (fill_cnt == 5'(BLOCK_WORDS));
   assign load_phase = (state == RUN) && (c < 7'(BLOCK_WORDS));
   assign load_end   = (state == RUN) && (c == 7'(BLOCK_WORDS - 1));
   // Gated by reset_n so every output reads 0 while reset is held.
   assign in_ready   = reset_n && !buf_full && !load_phase;
   assign xfer       = in_valid && in_ready;
   assign busy       = (state != IDLE) || (fill_cnt != 5'd0);
   assign resume_state = buf_full ? RUN : IDLE;

   always_comb begin
      state_nxt       = state;
      c_nxt           = c;
      ms_data         = 32'd0;
      ms_write_enable = 1'b0;
      ms_inner_busy   = 1'b0;
      core_init       = 1'b0;
      core_round_en   = 1'b0;
      core_round_idx  = 6'd0;
      core_update     = 1'b0;
      digest_valid    = 1'b0;
      case (state)
         IDLE: begin
            if (buf_full) begin
               state_nxt = RUN;
               c_nxt     = 7'd0;
            end
         end
         RUN: begin
            ms_inner_busy   = (c < 7'(ROUNDS));
            ms_write_enable = load_phase;
            if (load_phase) ms_data = blk_buf[c[3:0]];
            core_init       = (c == 7'd0) && buf_first;
            // Schedule output is registered, so round t sees Wt at c = t+1.
            core_round_en   = (c != 7'd0);
            if (c != 7'd0) core_round_idx = c[5:0] - 6'd1;
            if (c == 7'(ROUNDS)) state_nxt = UPDATE;
            else                 c_nxt     = c + 7'd1;
         end
         UPDATE: begin
            core_update = 1'b1;
            if (run_last) state_nxt = DONE;
            else          state_nxt = resume_state;
            c_nxt = 7'd0;
         end
         DONE: begin
            digest_valid = 1'b1;
            if (digest_ready) state_nxt = resume_state;
            c_nxt = 7'd0;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         c_nxt     = 7'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         c         <= 7'd0;
         fill_cnt  <= 5'd0;
         buf_first <= 1'b0;
         buf_last  <= 1'b0;
         run_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         c     <= c_nxt;
         if (abort) begin
            fill_cnt  <= 5'd0;
            buf_first <= 1'b0;
            buf_last  <= 1'b0;
            run_last  <= 1'b0;
         end else begin
            // Last flag moves to the running block before the next block can overwrite it.
            if (load_end) begin
               fill_cnt <= 5'd0;
               run_last <= buf_last;
            end else if (xfer) begin
               fill_cnt <= fill_cnt + 5'd1;
            end
            if (xfer && fill_cnt == 5'd0)  buf_first <= in_first;
            if (xfer && fill_cnt == 5'd15) buf_last  <= in_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) blk_buf[fill_cnt[3:0]] <= in_data;
   end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl: random block data, per-cycle expectations derived from block cycle number.
module tb_sha256_block_ctrl;

   typedef logic [31:0] blk_t [16];

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_first = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] ms_data;
   logic        ms_write_enable;
   logic        ms_inner_busy;
   logic        core_init;
   logic        core_round_en;
   logic [5:0]  core_round_idx;
   logic        core_update;
   logic        digest_valid;
   logic        digest_ready = 1'b0;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int s1, u1, s2, u2, tf, tf2, rel;
   blk_t b_abc, b1, b2;

   sha256_block_ctrl dut (
      .clk(clk), .reset_n(reset_n), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .in_ready(in_ready), .ms_data(ms_data), .ms_write_enable(ms_write_enable),
      .ms_inner_busy(ms_inner_busy), .core_init(core_init), .core_round_en(core_round_en),
      .core_round_idx(core_round_idx), .core_update(core_update),
      .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [45:0] all_outs();
      return {in_ready, ms_data, ms_write_enable, ms_inner_busy, core_init, core_round_en,
              core_round_idx, core_update, digest_valid, busy};
   endfunction

   task automatic rand_blk(output blk_t b);
      for (int i = 0; i < 16; i++) b[i] = $urandom;
   endtask

   // Streams 16 words; fv/lv give in_first/in_last per word index. Returns cycle at which buffer is full.
   task automatic send_block(input blk_t w, input logic [15:0] fv, input logic [15:0] lv,
                             input bit toggle, output int t_full);
      int i; int guard; bit on; bit acc;
      i = 0; guard = 0; on = 1'b1; acc = 1'b0;
      while (guard < 2000) begin
         @(negedge clk);
         guard++;
         if (acc) i++;
         if (i == 16) break;
         in_valid = on;
         in_data  = w[i];
         in_first = fv[i];
         in_last  = lv[i];
         acc = on && (in_ready === 1'b1);
         if (toggle) on = !on;
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 32'd0;
      t_full = cyc;
      chk("send_words", 64'(i), 64'd16);
   endtask

   // Expected schedule/core signals for block cycle k: loads for k<16, rounds k-1 for 1<=k<=64, update at 65.
   task automatic check_block(input blk_t w, input logic exp_init, output int start_cyc, output int upd_cyc);
      int guard;
      logic [43:0] obs, exp;
      logic [5:0]  e_idx;
      logic [31:0] e_dat;
      guard = 0; start_cyc = -1; upd_cyc = -1;
      while (ms_inner_busy !== 1'b1 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      chk("run_start_bound", 64'(guard < 400), 64'd1);
      if (guard >= 400) return;
      start_cyc = cyc;
      for (int k = 0; k <= 65; k++) begin
         if (k > 0) @(negedge clk);
         e_idx = (k >= 1 && k <= 64) ? 6'(k - 1) : 6'd0;
         e_dat = (k < 16) ? w[k] : 32'd0;
         obs = {ms_write_enable, ms_inner_busy, core_init, core_round_en, core_round_idx,
                core_update, digest_valid, ms_data};
         exp = {k < 16, k < 64, (k == 0) && exp_init, (k >= 1) && (k <= 64), e_idx,
                k == 65, 1'b0, e_dat};
         chk($sformatf("blk_cycle_%0d", k), 64'(obs), 64'(exp));
      end
      upd_cyc = cyc;
   endtask

   task automatic take_digest();
      @(negedge clk);
      chk("digest_valid_set", 64'(digest_valid), 64'd1);
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      chk("digest_released", 64'({digest_valid, busy, in_ready}), 64'(3'b001));
   endtask

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'(all_outs()), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset", 64'({in_ready, busy}), 64'(2'b10));

      // 1: "abc" single block
      for (int i = 0; i < 16; i++) b_abc[i] = 32'd0;
      b_abc[0]  = 32'h61626380;
      b_abc[15] = 32'h00000018;
      send_block(b_abc, 16'h0001, 16'h8000, 1'b0, tf);
      check_block(b_abc, 1'b1, s1, u1);
      chk("abc_start", 64'(s1 - tf), 64'd1);
      chk("abc_latency", 64'(u1 - tf), 64'd66);
      take_digest();

      // 2: two-block message, block 2 streamed during block 1 expand
      rand_blk(b1);
      rand_blk(b2);
      fork
         begin
            check_block(b1, 1'b1, s1, u1);
            check_block(b2, 1'b0, s2, u2);
         end
         begin
            send_block(b1, 16'h0001, 16'h0000, 1'b0, tf);
            send_block(b2, 16'h0000, 16'h8000, 1'b0, tf2);
         end
      join
      chk("b2b_start", 64'(s2), 64'(u1 + 1));
      chk("b2b_period", 64'(u2 - u1), 64'd66);
      take_digest();

      // 3: in_valid toggling during fill
      rand_blk(b1);
      send_block(b1, 16'h0001, 16'h8000, 1'b1, tf);
      check_block(b1, 1'b1, s1, u1);
      chk("toggle_start", 64'(s1 - tf), 64'd1);
      take_digest();

      // 4: digest_ready held off with the next block buffered
      rand_blk(b1);
      rand_blk(b2);
      fork
         check_block(b1, 1'b1, s1, u1);
         begin
            send_block(b1, 16'h0001, 16'h8000, 1'b0, tf);
            send_block(b2, 16'h0001, 16'h0000, 1'b0, tf2);
         end
      join
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("done_hold", 64'({digest_valid, ms_inner_busy, in_ready, busy}), 64'(4'b1001));
      end
      digest_ready = 1'b1;
      rel = cyc;
      @(negedge clk);
      digest_ready = 1'b0;
      check_block(b2, 1'b1, s2, u2);
      chk("run_after_ready", 64'(s2), 64'(rel + 1));
      @(negedge clk);
      chk("idle_after_nonlast", 64'({digest_valid, busy, in_ready}), 64'(3'b001));

      // 5: abort at c=30 with next block partly buffered, then reset mid-fill
      rand_blk(b1);
      send_block(b1, 16'h0001, 16'h8000, 1'b0, tf);
      @(negedge clk);
      chk("abort_run_started", 64'(ms_inner_busy), 64'd1);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         in_valid = (k < 30);
         in_data  = $urandom;
      end
      chk("abort_at_c30", 64'({core_round_en, core_round_idx}), 64'({1'b1, 6'd29}));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_flush", 64'({ms_inner_busy, core_round_en, busy, in_ready, ms_write_enable}),
          64'(5'b00010));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("midfill_busy", 64'({busy, in_ready, ms_inner_busy}), 64'(3'b110));
      #2 reset_n = 1'b0;
      #1 chk("async_reset_outs", 64'(all_outs()), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset_fill_clear", 64'({in_ready, busy}), 64'(2'b10));

      // 6: in_first on word 5 and in_last on word 3 are ignored
      rand_blk(b1);
      send_block(b1, 16'h0020, 16'h0008, 1'b0, tf);
      check_block(b1, 1'b0, s1, u1);
      @(negedge clk);
      chk("misplaced_flags", 64'({digest_valid, busy, in_ready}), 64'(3'b001));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
